// File: rtl/inst_rom_pkg.sv
// Shared constants, FSM encoding and byte-lane helper for the instruction ROM.
// The ROM has a byte-serial program-load port.
package inst_rom_pkg;

    localparam int unsigned INST_ADDR_W         = 32;
    localparam int unsigned INST_W              = 32;
    localparam int unsigned INST_MEM_DEPTH_LOG2 = 10;
    localparam logic [31:0] ZERO_WORD           = 32'h0000_0000;
    localparam logic        CHIP_ENABLE         = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } load_state_e;

    // Byte lane idx goes MSB-first: lane 0 is bits [31:24] and lane 3 is bits [7:0].
    function automatic logic [31:0] byte_insert(input logic [31:0] word,
                                                input logic [7:0]  data,
                                                input logic [1:0]  idx);
        logic [31:0] res;
        res = word;
        case (idx)
            2'd0:    res[31:24] = data;
            2'd1:    res[23:16] = data;
            2'd2:    res[15:8]  = data;
            2'd3:    res[7:0]   = data;
            default: res        = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/inst_rom.sv
// Instruction ROM with a combinational fetch port and a byte-serial program loader.
// Loaded bytes are packed big-endian into 32-bit words.
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = INST_MEM_DEPTH_LOG2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce_i,
    input  logic [INST_ADDR_W-1:0]  addr_i,
    output logic [INST_W-1:0]       inst_o,
    input  logic                    load_start_i,
    input  logic                    load_valid_i,
    input  logic [7:0]              load_byte_i,
    input  logic                    load_end_i,
    output logic                    load_ready_o,
    output logic                    load_busy_o,
    output logic [DEPTH_LOG2:0]     load_words_o,
    output logic                    overflow_o
);

    localparam int unsigned          DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]  WORD_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [INST_W-1:0]     mem_r [0:DEPTH-1];
    load_state_e           state_r;
    logic [DEPTH_LOG2:0]   word_cnt_r;
    logic [1:0]            byte_cnt_r;
    logic [31:0]           asm_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  overflow_r;

    logic                  accept_s;
    logic                  full_s;
    logic                  we_s;
    logic [DEPTH_LOG2-1:0] waddr_s;
    logic [31:0]           wdata_s;
    logic                  unused_addr_s;

    assign accept_s      = load_valid_i & ready_r;
    assign full_s        = (word_cnt_r == DEPTH_WORDS);
    assign unused_addr_s = ^addr_i[1:0];

    assign load_ready_o  = ready_r;
    assign load_busy_o   = busy_r;
    assign load_words_o  = word_cnt_r;
    assign overflow_o    = overflow_r;

    // Fetch path: zero added latency, blocked while a load owns the array.
    always_comb begin
        inst_o = ZERO_WORD;
        if ((ce_i == CHIP_ENABLE) && (state_r == ST_IDLE) &&
            (addr_i[INST_ADDR_W-1:DEPTH_LOG2+2] == {(INST_ADDR_W-DEPTH_LOG2-2){1'b0}})) begin
            inst_o = mem_r[addr_i[DEPTH_LOG2+1:2]];
        end else begin
            inst_o = ZERO_WORD;
        end
    end

    // Memory write request: a completed word in LOAD, or the padded partial word in FLUSH.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = word_cnt_r[DEPTH_LOG2-1:0];
        wdata_s = asm_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && !full_s && (byte_cnt_r == 2'd3)) begin
                    we_s    = 1'b1;
                    wdata_s = {asm_r[31:8], load_byte_i};
                end else begin
                    we_s    = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (byte_cnt_r != 2'd0) begin
                    we_s = 1'b1;
                end else begin
                    we_s = 1'b0;
                end
            end
            default: we_s = 1'b0;
        endcase
    end

    // Memory array: contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Load FSM, byte packer and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            word_cnt_r <= '0;
            byte_cnt_r <= 2'd0;
            asm_r      <= 32'h0000_0000;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_start_i) begin
                        state_r    <= ST_LOAD;
                        word_cnt_r <= '0;
                        byte_cnt_r <= 2'd0;
                        asm_r      <= 32'h0000_0000;
                        overflow_r <= 1'b0;
                        ready_r    <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        if (full_s) begin
                            overflow_r <= 1'b1;
                        end else if (byte_cnt_r == 2'd3) begin
                            word_cnt_r <= word_cnt_r + WORD_ONE;
                            byte_cnt_r <= 2'd0;
                            asm_r      <= 32'h0000_0000;
                        end else begin
                            asm_r      <= byte_insert(asm_r, load_byte_i, byte_cnt_r);
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                        end
                    end
                    // A byte arriving with load_end_i is taken first, so FLUSH sees it.
                    if (load_end_i) begin
                        state_r <= ST_FLUSH;
                        ready_r <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (byte_cnt_r != 2'd0) begin
                        word_cnt_r <= word_cnt_r + WORD_ONE;
                        byte_cnt_r <= 2'd0;
                        asm_r      <= 32'h0000_0000;
                    end
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: a default-depth instance plus a 4-word instance
// that exercises overflow.
module tb_inst_rom;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_ce = 1'b0, a_start = 1'b0, a_valid = 1'b0, a_end = 1'b0;
    logic [31:0] a_addr = 32'h0;
    logic [7:0]  a_byte = 8'h0;
    logic [31:0] a_inst;
    logic        a_ready, a_busy, a_ovf;
    logic [10:0] a_words;

    logic        b_ce = 1'b0, b_start = 1'b0, b_valid = 1'b0, b_end = 1'b0;
    logic [31:0] b_addr = 32'h0;
    logic [7:0]  b_byte = 8'h0;
    logic [31:0] b_inst;
    logic        b_ready, b_busy, b_ovf;
    logic [2:0]  b_words;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_rom #(.DEPTH_LOG2(10)) dut_a (
        .clk(clk), .rst(rst), .ce_i(a_ce), .addr_i(a_addr), .inst_o(a_inst),
        .load_start_i(a_start), .load_valid_i(a_valid), .load_byte_i(a_byte),
        .load_end_i(a_end), .load_ready_o(a_ready), .load_busy_o(a_busy),
        .load_words_o(a_words), .overflow_o(a_ovf)
    );

    inst_rom #(.DEPTH_LOG2(2)) dut_b (
        .clk(clk), .rst(rst), .ce_i(b_ce), .addr_i(b_addr), .inst_o(b_inst),
        .load_start_i(b_start), .load_valid_i(b_valid), .load_byte_i(b_byte),
        .load_end_i(b_end), .load_ready_o(b_ready), .load_busy_o(b_busy),
        .load_words_o(b_words), .overflow_o(b_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit sel);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        tick();
        b_start = 1'b0; a_start = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [7:0] data, input bit with_end);
        if (sel) begin b_valid = 1'b1; b_byte = data; b_end = with_end; end
        else     begin a_valid = 1'b1; a_byte = data; a_end = with_end; end
        tick();
        a_valid = 1'b0; a_end = 1'b0; b_valid = 1'b0; b_end = 1'b0;
        if (with_end) tick();
    endtask

    task automatic finish_load(input bit sel);
        if (sel) b_end = 1'b1; else a_end = 1'b1;
        tick();
        a_end = 1'b0; b_end = 1'b0;
        tick();
    endtask

    task automatic fetch_a(input string tag, input logic ce, input logic [31:0] addr,
                           input logic [31:0] exp);
        a_ce = ce; a_addr = addr;
        #1;
        check(tag, a_inst, exp);
        a_ce = 1'b0;
    endtask

    task automatic fetch_b(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        b_ce = 1'b1; b_addr = addr;
        #1;
        check(tag, b_inst, exp);
        b_ce = 1'b0;
    endtask

    logic [7:0] prog1 [8] = '{8'h3C, 8'h01, 8'h00, 8'h01, 8'h34, 8'h21, 8'h00, 8'h20};
    logic [7:0] prog2 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    initial begin
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_ready", {31'h0, a_ready}, 32'h0);
        check("rst_busy",  {31'h0, a_busy},  32'h0);
        check("rst_words", {21'h0, a_words}, 32'h0);
        check("rst_ovf",   {31'h0, a_ovf},   32'h0);

        // Two full words
        start(1'b0);
        check("load_ready", {31'h0, a_ready}, 32'h1);
        for (int i = 0; i < 8; i++) send(1'b0, prog1[i], 1'b0);
        fetch_a("fetch_in_load", 1'b1, 32'h0, 32'h0);
        check("busy_in_load", {31'h0, a_busy}, 32'h1);
        a_end = 1'b1; tick(); a_end = 1'b0;
        check("flush_busy",  {31'h0, a_busy},  32'h1);
        check("flush_ready", {31'h0, a_ready}, 32'h0);
        tick();
        check("idle_busy", {31'h0, a_busy}, 32'h0);
        check("words_p1", {21'h0, a_words}, 32'd2);
        fetch_a("p1_w0", 1'b1, 32'h0, 32'h3C01_0001);
        fetch_a("p1_w1", 1'b1, 32'h4, 32'h3421_0020);
        fetch_a("p1_lsb_ignored", 1'b1, 32'h7, 32'h3421_0020);
        fetch_a("ce_off", 1'b0, 32'h0, 32'h0);
        fetch_a("addr_range", 1'b1, 32'h0000_1000, 32'h0);

        // load_end in IDLE is ignored
        a_end = 1'b1; tick(); a_end = 1'b0;
        check("end_in_idle", {31'h0, a_busy}, 32'h0);
        check("words_hold", {21'h0, a_words}, 32'd2);

        // Partial trailing word
        start(1'b0);
        for (int i = 0; i < 5; i++) send(1'b0, prog2[i], 1'b0);
        finish_load(1'b0);
        check("words_p2", {21'h0, a_words}, 32'd2);
        fetch_a("p2_w0", 1'b1, 32'h0, 32'hAABB_CCDD);
        fetch_a("p2_w1", 1'b1, 32'h4, 32'hEE00_0000);

        // Restart ignored mid-load; byte coincident with load_end is kept
        start(1'b0);
        send(1'b0, 8'h11, 1'b0); send(1'b0, 8'h22, 1'b0);
        send(1'b0, 8'h33, 1'b0); send(1'b0, 8'h44, 1'b0);
        start(1'b0);
        check("restart_ignored", {21'h0, a_words}, 32'd1);
        send(1'b0, 8'h55, 1'b0); send(1'b0, 8'h66, 1'b0);
        send(1'b0, 8'h77, 1'b1);
        check("words_p3", {21'h0, a_words}, 32'd2);
        fetch_a("p3_w0", 1'b1, 32'h0, 32'h1122_3344);
        fetch_a("p3_w1", 1'b1, 32'h4, 32'h5566_7700);

        // Overflow on the 4-word instance
        start(1'b1);
        for (int i = 1; i <= 20; i++) send(1'b1, 8'(i), 1'b0);
        finish_load(1'b1);
        check("b_words", {29'h0, b_words}, 32'd4);
        check("b_ovf",   {31'h0, b_ovf},   32'h1);
        fetch_b("b_w0", 32'h0, 32'h0102_0304);
        fetch_b("b_w3", 32'hC, 32'h0D0E_0F10);
        fetch_b("b_range", 32'h10, 32'h0);
        start(1'b1);
        check("b_ovf_clear", {31'h0, b_ovf}, 32'h0);
        finish_load(1'b1);

        // Reset mid-word abandons the partial word
        start(1'b0);
        send(1'b0, 8'h01, 1'b0); send(1'b0, 8'h02, 1'b0);
        send(1'b0, 8'h03, 1'b0); send(1'b0, 8'h04, 1'b0);
        send(1'b0, 8'h05, 1'b0); send(1'b0, 8'h06, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy",  {31'h0, a_busy},  32'h0);
        check("rst_mid_ready", {31'h0, a_ready}, 32'h0);
        check("rst_mid_words", {21'h0, a_words}, 32'h0);
        rst = 1'b0;
        tick();
        fetch_a("rst_keep_w0", 1'b1, 32'h0, 32'h0102_0304);
        fetch_a("rst_keep_w1", 1'b1, 32'h4, 32'h5566_7700);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10; log2 of word capacity (1024 x 32-bit words).
REQ-002 SHALL have port clk, input, 1 bit; single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port ce_i, input, 1 bit; fetch enable from pc_reg (rom_ce_o).
REQ-005 SHALL have port addr_i, input, 32 bits; byte fetch address (rom_addr_o).
REQ-006 SHALL have port inst_o, output, 32 bits; fetched instruction to core (rom_data_i).
REQ-007 SHALL have port load_start_i, input, 1 bit; pulse that begins a program load.
REQ-008 SHALL have port load_valid_i, input, 1 bit; load byte present.
REQ-009 SHALL have port load_byte_i, input, 8 bits; load byte, big-endian order within each word.
REQ-010 SHALL have port load_end_i, input, 1 bit; pulse that ends a program load.
REQ-011 SHALL have port load_ready_o, output, 1 bit; bytes accepted this cycle.
REQ-012 SHALL have port load_busy_o, output, 1 bit; load in progress, fetches blocked.
REQ-013 SHALL have port load_words_o, output, DEPTH_LOG2+1 bits; number of words written by the last or current load.
REQ-014 SHALL have port overflow_o, output, 1 bit; sticky flag, bytes dropped beyond capacity.

Function
REQ-015 SHALL implement the fetch path combinationally: inst_o = mem[addr_i[DEPTH_LOG2+1:2]] when ce_i=1, state=IDLE and addr_i[31:DEPTH_LOG2+2]=0; otherwise 32'h0 (`ZeroWord). This gives zero added latency, so the if_id timing is unchanged.
REQ-016 SHALL ignore addr_i[1:0] on fetch.
REQ-017 SHALL implement the FSM states IDLE, LOAD and FLUSH, with these transitions:
 - IDLE -> LOAD on load_start_i.
 - LOAD -> FLUSH on load_end_i.
 - FLUSH -> IDLE after exactly one cycle.
REQ-018 SHALL, on entering LOAD, clear the word counter, the byte counter (2-bit), the assembly register and overflow_o.
REQ-019 SHALL drive load_ready_o=1 only in LOAD; a byte is accepted when load_valid_i and load_ready_o are both 1.
REQ-020 SHALL shift each accepted byte into the assembly register MSB-first: byte 0 goes to bits [31:24] and byte 3 to bits [7:0].
REQ-021 SHALL, on the 4th accepted byte, write {assembled[31:8], load_byte_i} to mem[word counter] in the same cycle, then increment the word counter and set the byte counter to 0.
REQ-022 SHALL, in FLUSH with byte counter != 0, write the partial word zero-padded in the low bytes and increment the word counter; with byte counter = 0, no write occurs.
REQ-023 SHALL, when the word counter equals 2**DEPTH_LOG2, drop further bytes without writing and set overflow_o, held until the next load_start_i.
REQ-024 SHALL, if load_valid_i and load_end_i are asserted in the same cycle in LOAD, accept the byte first; FLUSH then includes it.
REQ-025 SHALL ignore load_start_i in LOAD and FLUSH; a load cannot restart mid-load.
REQ-026 SHALL ignore load_end_i in IDLE.
REQ-027 SHALL drive load_busy_o=1 in LOAD and FLUSH; while busy, inst_o=0, which decodes as NOP (sll $0).
REQ-028 SHALL update load_words_o live during a load and hold it in IDLE.

Reset
REQ-029 SHALL, on rst, asynchronously set the state to IDLE and load_ready_o, load_busy_o, load_words_o, overflow_o, both counters and the assembly register to 0.
REQ-030 SHALL NOT reset memory array contents.
REQ-031 SHALL, on rst asserted mid-load, abandon the load: an unwritten partial word is lost, and already-written words persist.

Structure
REQ-032 SHALL take widths and constants (`InstAddrBus, `InstBus, `ZeroWord, `ChipEnable) from the shared defines.v.
REQ-033 SHALL add new constants InstMemDepthLog2 and the FSM state encodings to defines.v.
REQ-034 SHALL be flat with no sub-module; the byte packer and FSM are small enough to stay inline.

Verification
REQ-035 SHALL cover: load_start, bytes 3C 01 00 01 34 21 00 20, load_end -> mem[0]=3C010001, mem[1]=34210020, load_words_o=2, then ce_i=1, addr_i=4 -> inst_o=34210020.
REQ-036 SHALL cover: load 5 bytes AA BB CC DD EE then load_end -> mem[1]=EE000000, load_words_o=2.
REQ-037 SHALL cover: DEPTH_LOG2=2, load 20 bytes -> 4 words written, overflow_o=1, load_words_o=4, mem[0] intact.
REQ-038 SHALL cover: fetch addr_i=0 during LOAD -> inst_o=0 and load_busy_o=1; ce_i=0 in IDLE -> inst_o=0; addr_i=32'h0000_1000 with DEPTH_LOG2=10 -> inst_o=0.
REQ-039 SHALL cover: assert rst after 2 bytes of a word -> state=IDLE, load_words_o=0, outputs 0, the earlier full word still readable.
REQ-040 SHALL cover: openmips plus inst_rom, load an ori/addi program over the load port, release the core from rst -> regfile values match the program's expected results.
